stack_ctrl: RTL

Push-down stack controller that sits directly upstream of the word array. It accepts push/pop requests, keeps the stack pointer, and drives a one-hot row select, write enable and write data into the words. It registers the word-array read data as the popped value. It reports full/empty/error status to the surrounding design.

---
 rtl/stack_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/stack_ctrl.sv
// Push-down stack controller driving a one-hot word array.
// Optional feature macro: STACK_PEEK_EN adds a Peek_i request that reads the
// top of stack without popping it.
module stack_ctrl #(
   parameter int unsigned BUSWIDTH = 8,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AWIDTH   = 3
) (
   input  logic                Clk_i,
   input  logic                RstN_i,
   input  logic                Push_i,
   input  logic                Pop_i,
`ifdef STACK_PEEK_EN
   input  logic                Peek_i,
`endif
   input  logic [BUSWIDTH-1:0] data_i,
   input  logic [BUSWIDTH-1:0] RData_i,
   output logic [DEPTH-1:0]    RowSel_o,
   output logic                WEn_o,
   output logic [BUSWIDTH-1:0] WData_o,
   output logic [BUSWIDTH-1:0] data_o,
   output logic                Valid_o,
   output logic                Full_o,
   output logic                Empty_o,
   output logic                Busy_o,
   output logic                Err_o
);

   localparam int unsigned SPW = AWIDTH + 1;
   localparam logic [DEPTH-1:0] ROW_ONE  = DEPTH'(1);
   localparam logic [SPW-1:0]   SP_DEPTH = SPW'(DEPTH);
   localparam logic [SPW-1:0]   SP_ONE   = SPW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [SPW-1:0]        sp_q, sp_d;
   logic                  peek_q, peek_d;
   logic                  peek_req;
   logic [DEPTH-1:0]      row_d;
   logic                  wen_d;
   logic [BUSWIDTH-1:0]   wdata_d;
   logic [BUSWIDTH-1:0]   dout_d;
   logic                  valid_d;
   logic                  err_d;

`ifdef STACK_PEEK_EN
   assign peek_req = Peek_i;
`else
   assign peek_req = 1'b0;
`endif

   // State, stack pointer and peek marker registers
   always_ff @(posedge Clk_i or negedge RstN_i) begin
      if (!RstN_i) begin
         state_q <= S_IDLE;
         sp_q    <= '0;
         peek_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
         peek_q  <= peek_d;
      end
   end

   // Request arbitration, next state and next output values
   always_comb begin
      state_d = state_q;
      sp_d    = sp_q;
      peek_d  = peek_q;
      row_d   = '0;
      wen_d   = 1'b0;
      wdata_d = WData_o;
      dout_d  = data_o;
      valid_d = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if ((Push_i && Pop_i) || (peek_req && (Push_i || Pop_i))) begin
               err_d = 1'b1;
            end else if (Push_i && Full_o) begin
               err_d = 1'b1;
            end else if (Pop_i && Empty_o) begin
               err_d = 1'b1;
            end else if (peek_req && Empty_o) begin
               err_d = 1'b1;
            end else if (Push_i) begin
               wdata_d = data_i;
               row_d   = ROW_ONE << sp_q;
               wen_d   = 1'b1;
               state_d = S_WRITE;
            end else if (Pop_i || peek_req) begin
               row_d   = ROW_ONE << SPW'(sp_q - SP_ONE);
               peek_d  = peek_req;
               state_d = S_READ;
            end
         end
         S_WRITE: begin
            sp_d    = SPW'(sp_q + SP_ONE);
            state_d = S_IDLE;
         end
         S_READ: begin
            dout_d  = RData_i;
            valid_d = 1'b1;
            if (!peek_q) begin
               sp_d = SPW'(sp_q - SP_ONE);
            end
            peek_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Registered outputs; flags follow the next stack pointer value
   always_ff @(posedge Clk_i or negedge RstN_i) begin
      if (!RstN_i) begin
         RowSel_o <= '0;
         WEn_o    <= 1'b0;
         WData_o  <= '0;
         data_o   <= '0;
         Valid_o  <= 1'b0;
         Full_o   <= 1'b0;
         Empty_o  <= 1'b1;
         Busy_o   <= 1'b0;
         Err_o    <= 1'b0;
      end else begin
         RowSel_o <= row_d;
         WEn_o    <= wen_d;
         WData_o  <= wdata_d;
         data_o   <= dout_d;
         Valid_o  <= valid_d;
         Full_o   <= (sp_d == SP_DEPTH);
         Empty_o  <= (sp_d == '0);
         Busy_o   <= (state_d != S_IDLE);
         Err_o    <= err_d;
      end
   end

endmodule
